// File: rtl/ti_sbox_pkg.sv
// Shared types and LFSR helpers for the threshold-implementation S-box input stage.
package ti_sbox_pkg;

  localparam logic [15:0] LFSR_POLY     = 16'hB400;
  localparam logic [15:0] LFSR_FALLBACK = 16'hACE1;

  typedef logic [7:0] share_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MIX  = 2'd1,
    OUT  = 2'd2
  } share_gen_state_t;

  // An all-zero LFSR would never leave zero, so zero is mapped to the fallback value.
  function automatic logic [15:0] lfsr_sanitize(input logic [15:0] v);
    return (v == 16'h0000) ? LFSR_FALLBACK : v;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    logic [15:0] nxt;
    nxt = (cur >> 1) ^ (cur[0] ? LFSR_POLY : 16'h0000);
    return lfsr_sanitize(nxt);
  endfunction

endpackage

// File: rtl/ti_lfsr16.sv
// Free-running 16-bit Galois mask LFSR with zero-lock guard.
// Optional runtime seed load when TI_SHARE_SEED_LOAD_EN is defined.
module ti_lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef TI_SHARE_SEED_LOAD_EN
  input  logic        seed_we,
  input  logic [15:0] seed_data,
`endif
  output logic [15:0] lfsr
);
  import ti_sbox_pkg::*;

  localparam logic [15:0] RESET_VAL = lfsr_sanitize(SEED);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Next LFSR value: a seed load overrides the regular step.
  always_comb begin
`ifdef TI_SHARE_SEED_LOAD_EN
    if (seed_we) begin
      lfsr_d = lfsr_sanitize(seed_data);
    end else begin
      lfsr_d = lfsr_next(lfsr_q);
    end
`else
    lfsr_d = lfsr_next(lfsr_q);
`endif
  end

  // LFSR state register; steps every cycle regardless of the consumer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= RESET_VAL;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr = lfsr_q;

endmodule

// File: rtl/ti_share_gen.sv
// Splits a plaintext byte into three Boolean shares for the TI S-box core.
// Build option TI_SHARE_SEED_LOAD_EN adds the seed_we/seed_data LFSR load port.
module ti_share_gen #(
  parameter logic [15:0] SEED       = 16'hACE1,
  parameter int unsigned MIX_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
`ifdef TI_SHARE_SEED_LOAD_EN
  input  logic        seed_we,
  input  logic [15:0] seed_data,
`endif
  output logic [7:0]  share0,
  output logic [7:0]  share1,
  output logic [7:0]  share2
);
  import ti_sbox_pkg::*;

  localparam logic [7:0] MIX_LOAD = 8'(MIX_CYCLES - 1);

  logic [15:0]      lfsr_s;
  share_gen_state_t state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  share_t           x_q, x_d;
  share_t           share0_q, share0_d;
  share_t           share1_q, share1_d;
  share_t           share2_q, share2_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  ti_lfsr16 #(
    .SEED (SEED)
  ) u_lfsr (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef TI_SHARE_SEED_LOAD_EN
    .seed_we   (seed_we),
    .seed_data (seed_data),
`endif
    .lfsr      (lfsr_s)
  );

  // FSM next state, mix counter, plaintext capture and share generation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    share0_d = share0_q;
    share1_d = share1_q;
    share2_d = share2_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          x_d     = in_data;
          cnt_d   = MIX_LOAD;
          state_d = MIX;
        end else begin
          state_d = IDLE;
        end
      end
      MIX: begin
        // Shares are written only while out_valid is low, so a presented share never changes.
        if (cnt_q == 8'd0) begin
          share1_d = lfsr_s[7:0];
          share2_d = lfsr_s[15:8];
          share0_d = x_q ^ lfsr_s[7:0] ^ lfsr_s[15:8];
          state_d  = OUT;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      OUT: begin
        if (out_ready && out_valid_q) begin
          x_d     = 8'h00;
          state_d = IDLE;
        end else begin
          state_d = OUT;
        end
      end
      default: begin
        x_d     = 8'h00;
        cnt_d   = 8'h00;
        state_d = IDLE;
      end
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == OUT);
  end

  // State, datapath and handshake output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 8'h00;
      x_q         <= 8'h00;
      share0_q    <= 8'h00;
      share1_q    <= 8'h00;
      share2_q    <= 8'h00;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      share0_q    <= share0_d;
      share1_q    <= share1_d;
      share2_q    <= share2_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign share0    = share0_q;
  assign share1    = share1_q;
  assign share2    = share2_q;

endmodule

// File: tb/tb_ti_share_gen.sv
// Scoreboard bench for ti_share_gen: stimulus pushes expected shares, a monitor pops on handshake.
module tb_ti_share_gen;

  localparam int M = 8;

  typedef struct {
    logic [7:0] x;
    logic [7:0] s0;
    logic [7:0] s1;
    logic [7:0] s2;
    int         acc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  share0, share1, share2;
`ifdef TI_SHARE_SEED_LOAD_EN
  logic        seed_we;
  logic [15:0] seed_data;
`endif

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [15:0] m_lfsr;
  exp_t        sb_q[$];
  logic [15:0] mask_hist[$];

  ti_share_gen #(.SEED(16'hACE1), .MIX_CYCLES(M)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef TI_SHARE_SEED_LOAD_EN
    .seed_we   (seed_we),
    .seed_data (seed_data),
`endif
    .share0    (share0),
    .share1    (share1),
    .share2    (share2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] mstep(input logic [15:0] v);
    logic [15:0] n;
    n = {1'b0, v[15:1]};
    if (v[0]) n = n ^ 16'hB400;
    if (n == 16'h0000) n = 16'hACE1;
    return n;
  endfunction

  function automatic logic [15:0] mpow(input logic [15:0] v, input int k);
    logic [15:0] r;
    r = v;
    for (int i = 0; i < k; i++) r = mstep(r);
    return r;
  endfunction

  // Reference LFSR, value valid for the current cycle
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
`ifdef TI_SHARE_SEED_LOAD_EN
    else if (seed_we) m_lfsr <= (seed_data == 16'h0000) ? 16'hACE1 : seed_data;
`endif
    else m_lfsr <= mstep(m_lfsr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timeout at t=%0t", name, $time);
  endtask

  // Called #1 after a posedge; returns #1 after the accepting edge
  task automatic send(input logic [7:0] x, input bit push_exp);
    int n;
    logic [15:0] lv;
    exp_t e;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      timeout("send_wait_in_ready");
    end else begin
      if (push_exp) begin
        lv   = mpow(m_lfsr, M);
        e.x  = x;
        e.s1 = lv[7:0];
        e.s2 = lv[15:8];
        e.s0 = x ^ lv[7:0] ^ lv[15:8];
        e.acc = cyc;
        sb_q.push_back(e);
      end
      in_valid = 1'b1;
      in_data  = x;
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (sb_q.size() != 0) timeout("drain_scoreboard");
    @(posedge clk); #1;
  endtask

  // Monitor: compares presented shares against the scoreboard head
  initial begin : monitor
    exp_t       e;
    bit         head_seen;
    bit         ready_next;
    logic [23:0] held;
    head_seen  = 1'b0;
    ready_next = 1'b0;
    held       = 24'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        head_seen  = 1'b0;
        ready_next = 1'b0;
      end else begin
        if (ready_next) begin
          chk("in_ready_after_out", {31'd0, in_ready}, 32'd1);
          ready_next = 1'b0;
        end
        if (out_valid) begin
          if (sb_q.size() == 0) begin
            timeout("unexpected_out_valid");
          end else begin
            e = sb_q[0];
            if (!head_seen) begin
              chk("latency", cyc - e.acc, M + 1);
              chk("reconstruct", {24'd0, share0 ^ share1 ^ share2}, {24'd0, e.x});
              chk("share0", {24'd0, share0}, {24'd0, e.s0});
              chk("share1", {24'd0, share1}, {24'd0, e.s1});
              chk("share2", {24'd0, share2}, {24'd0, e.s2});
              mask_hist.push_back({share2, share1});
              held      = {share0, share1, share2};
              head_seen = 1'b1;
            end else begin
              chk("shares_stable", {8'd0, share0, share1, share2}, {8'd0, held});
              chk("in_ready_during_out", {31'd0, in_ready}, 32'd0);
            end
            if (out_ready) begin
              void'(sb_q.pop_front());
              head_seen  = 1'b0;
              ready_next = 1'b1;
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int n;
    logic [15:0] lv;
    exp_t e;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
`ifdef TI_SHARE_SEED_LOAD_EN
    seed_we   = 1'b0;
    seed_data = 16'h0000;
`endif
    #8;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_shares", {8'd0, share0, share1, share2}, 32'd0);
    chk("rst_lfsr", {16'd0, dut.lfsr_s}, 32'h0000ACE1);
    #4 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("lfsr_first_step", {16'd0, dut.lfsr_s}, 32'h0000E270);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Basic transaction
    send(8'h53, 1'b1);
    drain();

    // Back-pressure for 20 cycles
    out_ready = 1'b0;
    send(8'hC3, 1'b1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!out_valid) timeout("bp_wait_out_valid");
    repeat (20) @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    // Back-to-back bytes
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    drain();
    n_checks++;
    if (mask_hist.size() < 2) begin
      n_errors++;
      $display("FAIL mask_history: got %0d entries expected at least 2", mask_hist.size());
    end else if (mask_hist[mask_hist.size()-1] == mask_hist[mask_hist.size()-2]) begin
      n_errors++;
      $display("FAIL masks_differ: got %h twice expected distinct", mask_hist[mask_hist.size()-1]);
    end

    // Asynchronous reset in MIX cycle 4
    send(8'h77, 1'b1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    sb_q.delete();
    #2;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_shares", {8'd0, share0, share1, share2}, 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (15) @(posedge clk);
    #1;
    send(8'hA5, 1'b1);
    drain();

`ifdef TI_SHARE_SEED_LOAD_EN
    // Zero seed maps to the fallback value
    seed_we   = 1'b1;
    seed_data = 16'h0000;
    @(posedge clk); #1;
    seed_we   = 1'b0;
    chk("seed_zero", {16'd0, dut.lfsr_s}, 32'h0000ACE1);

    // Seed load in the first MIX cycle: becomes the LFSR value in MIX cycle 2
    send(8'h3C, 1'b0);
    lv   = mpow(16'h1234, M - 2);
    e.x  = 8'h3C;
    e.s1 = lv[7:0];
    e.s2 = lv[15:8];
    e.s0 = 8'h3C ^ lv[7:0] ^ lv[15:8];
    e.acc = cyc - 1;
    sb_q.push_back(e);
    seed_we   = 1'b1;
    seed_data = 16'h1234;
    @(posedge clk); #1;
    seed_we   = 1'b0;
    chk("seed_load_mix", {16'd0, dut.lfsr_s}, 32'h00001234);
    drain();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
